score_ctrl: RTL and testbench

//  Synchronous scheduler for the 3-digit BCD score shown by the score renderer.

---
 rtl/score_if.sv | 26 ++
 rtl/score_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_score_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_if.sv
// Score controller bus: hit requests/acks, game control and HUD-facing score outputs.
interface score_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DIGITS  = 3
);
  logic [NUM_SRC-1:0]   hit_req;
  logic [8*NUM_SRC-1:0] hit_pts;
  logic [NUM_SRC-1:0]   hit_ack;
  logic                 game_over;
  logic                 clear_score;
  logic [4*DIGITS-1:0]  score_bcd;
  logic [4*DIGITS-1:0]  hi_bcd;
  logic                 busy;
  logic                 fifo_full;
  logic                 saturated;

  modport master (
    output hit_req, hit_pts, game_over, clear_score,
    input  hit_ack, score_bcd, hi_bcd, busy, fifo_full, saturated
  );

  modport slave (
    input  hit_req, hit_pts, game_over, clear_score,
    output hit_ack, score_bcd, hi_bcd, busy, fifo_full, saturated
  );
endinterface

// File: rtl/score_ctrl.sv
// Score scheduler: round-robin intake of BCD point awards into a small FIFO, digit-serial
// BCD accumulation into the score, saturation at all-9s and high-score latch at game over.
module score_ctrl #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIGITS     = 3
) (
  input  logic   Clk,
  input  logic   reset_n,
  score_if.slave bus
);

  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned SrcW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned ScoreW = 4 * DIGITS;

  localparam logic [SrcW:0]       NumSrcW   = (SrcW + 1)'(NUM_SRC);
  localparam logic [SrcW-1:0]     LastSrc   = SrcW'(NUM_SRC - 1);
  localparam logic [CntW-1:0]     DepthW    = CntW'(FIFO_DEPTH);
  localparam logic [IdxW-1:0]     LastIdx   = IdxW'(DIGITS - 1);
  localparam logic [ScoreW-1:0]   AllNines  = {DIGITS{4'h9}};

  typedef enum logic [1:0] {StIdle, StAdd, StCommit, StHiscore} state_e;

  state_e              state_q, state_d;
  logic [SrcW-1:0]     rr_q, rr_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [7:0]          fifo_mem_q [FIFO_DEPTH];
  logic [7:0]          addend_q, addend_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [ScoreW-1:0]   work_q, work_d;
  logic [ScoreW-1:0]   score_q, score_d;
  logic [ScoreW-1:0]   hi_q, hi_d;
  logic                sat_q, sat_d;
  logic                hi_done_q, hi_done_d;

  logic                fifo_full;
  logic                fifo_empty;
  logic                grant_vld;
  logic [SrcW-1:0]     grant_idx;
  logic [SrcW:0]       cand_sum;
  logic [SrcW-1:0]     cand;
  logic                push;
  logic                pop;
  logic [7:0]          pts_raw;
  logic [7:0]          push_data;
  logic [3:0]          add_digit;
  logic [4:0]          digit_sum;

  assign fifo_full  = (cnt_q == DepthW);
  assign fifo_empty = (cnt_q == '0);

  // Round-robin search starting at rr_q; first requester found wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand_sum = {1'b0, rr_q} + (SrcW + 1)'(k);
      if (cand_sum >= NumSrcW) begin
        cand_sum = cand_sum - NumSrcW;
      end
      cand = cand_sum[SrcW-1:0];
      if (!grant_vld && bus.hit_req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Grant qualification, ack pulse, digit clamping of the pushed award and pointer advance.
  always_comb begin
    push        = grant_vld && !fifo_full && !bus.game_over && !bus.clear_score;
    bus.hit_ack = '0;
    if (push) begin
      bus.hit_ack[grant_idx] = 1'b1;
    end
    pts_raw   = bus.hit_pts[{grant_idx, 3'b000} +: 8];
    push_data = {(pts_raw[7:4] > 4'd9) ? 4'd9 : pts_raw[7:4],
                 (pts_raw[3:0] > 4'd9) ? 4'd9 : pts_raw[3:0]};
    rr_d = rr_q;
    if (push) begin
      rr_d = (grant_idx == LastSrc) ? '0 : grant_idx + SrcW'(1);
    end
  end

  // FIFO bookkeeping; a clear flushes everything regardless of push/pop.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (bus.clear_score) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  // Award storage; contents beyond the valid window are don't-care so no reset is needed.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Scheduler FSM next-state: pop, per-digit BCD add into the shadow sum, commit, hiscore.
  always_comb begin
    state_d   = state_q;
    addend_d  = addend_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    work_d    = work_q;
    score_d   = score_q;
    hi_d      = hi_q;
    sat_d     = sat_q;
    hi_done_d = hi_done_q;
    pop       = 1'b0;
    add_digit = '0;
    digit_sum = '0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          addend_d = fifo_mem_q[rd_ptr_q];
          idx_d    = '0;
          carry_d  = 1'b0;
          state_d  = StAdd;
        end else if (bus.game_over && !hi_done_q) begin
          state_d = StHiscore;
        end
      end
      StAdd: begin
        // Awards carry only two digits; upper digits add zero plus carry.
        if (idx_q == IdxW'(0)) begin
          add_digit = addend_q[3:0];
        end else if (idx_q == IdxW'(1)) begin
          add_digit = addend_q[7:4];
        end
        digit_sum = {1'b0, score_q[{idx_q, 2'b00} +: 4]} + {1'b0, add_digit} + {4'b0000, carry_q};
        if (digit_sum > 5'd9) begin
          work_d[{idx_q, 2'b00} +: 4] = 4'(digit_sum - 5'd10);
          carry_d                     = 1'b1;
        end else begin
          work_d[{idx_q, 2'b00} +: 4] = digit_sum[3:0];
          carry_d                     = 1'b0;
        end
        if (idx_q == LastIdx) begin
          state_d = StCommit;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StCommit: begin
        if (carry_q) begin
          score_d = AllNines;
          sat_d   = 1'b1;
        end else begin
          score_d = work_q;
        end
        state_d = (bus.game_over && fifo_empty) ? StHiscore : StIdle;
      end
      StHiscore: begin
        // Digits are all <=9, so binary compare equals BCD magnitude compare.
        if (score_q > hi_q) begin
          hi_d = score_q;
        end
        hi_done_d = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (!bus.game_over) begin
      hi_done_d = 1'b0;
    end

    if (bus.clear_score) begin
      state_d   = StIdle;
      score_d   = '0;
      sat_d     = 1'b0;
      hi_done_d = 1'b0;
      carry_d   = 1'b0;
      idx_d     = '0;
    end
  end

  // State registers; reset clears everything, dropping any add in progress.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      rr_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      addend_q  <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      work_q    <= '0;
      score_q   <= '0;
      hi_q      <= '0;
      sat_q     <= 1'b0;
      hi_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      addend_q  <= addend_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      work_q    <= work_d;
      score_q   <= score_d;
      hi_q      <= hi_d;
      sat_q     <= sat_d;
      hi_done_q <= hi_done_d;
    end
  end

  // Registered outputs to the HUD plus status flags.
  always_comb begin
    bus.score_bcd = score_q;
    bus.hi_bcd    = hi_q;
    bus.saturated = sat_q;
    bus.fifo_full = fifo_full;
    bus.busy      = (state_q != StIdle) || !fifo_empty;
  end

endmodule

// File: tb/tb_score_ctrl.sv
// Bench for score_ctrl: every cycle is compared against a decimal, queue-based reference model;
// a vector table and hand-written sequences check fixed expected scores at the corner cases.
module tb_score_ctrl;
  localparam int NSRC  = 4;
  localparam int DEPTH = 4;
  localparam int DIG   = 3;

  logic Clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 Clk = ~Clk;

  logic [NSRC-1:0]   req = '0;
  logic [8*NSRC-1:0] pts = '0;
  logic              go  = 1'b0;
  logic              clr = 1'b0;

  score_if #(.NUM_SRC(NSRC), .DIGITS(DIG)) bus ();
  assign bus.hit_req     = req;
  assign bus.hit_pts     = pts;
  assign bus.game_over   = go;
  assign bus.clear_score = clr;

  score_ctrl #(.NUM_SRC(NSRC), .FIFO_DEPTH(DEPTH), .DIGITS(DIG)) dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state (decimal values, award queue, engine countdown)
  int  m_score, m_hi, m_cur, m_eng, m_rr;
  bit  m_sat, m_hs, m_hidone;
  int  m_q[$];
  logic [NSRC-1:0] last_ack;
  bit  saw_full;
  bit  any_ack;

  typedef struct {
    bit          clr_first;
    logic [7:0]  pts;
    logic [11:0] exp_score;
    bit          exp_sat;
  } vec_t;
  vec_t vecs[7];

  function automatic logic [11:0] int2bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  function automatic int clamp_pts(input logic [7:0] p);
    int h, l;
    h = int'(p[7:4]);
    l = int'(p[3:0]);
    if (h > 9) h = 9;
    if (l > 9) l = 9;
    return h * 10 + l;
  endfunction

  function automatic bit got_ack(input int s);
    logic [NSRC-1:0] sh;
    sh = last_ack >> s;
    return sh[0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_score = 0; m_hi = 0; m_cur = 0; m_eng = 0; m_rr = 0;
    m_sat = 1'b0; m_hs = 1'b0; m_hidone = 1'b0;
    m_q.delete();
  endtask

  // One clock: compare DUT to model at the falling edge, then advance the model.
  task automatic step();
    logic [NSRC-1:0] e_ack;
    logic [NSRC-1:0] sh;
    int gi;
    @(negedge Clk);
    e_ack = '0;
    gi    = -1;
    if (!clr && !go && m_q.size() < DEPTH) begin
      for (int k = 0; k < NSRC; k++) begin
        sh = req >> ((m_rr + k) % NSRC);
        if (gi < 0 && sh[0]) gi = (m_rr + k) % NSRC;
      end
    end
    if (gi >= 0) e_ack = NSRC'(1) << gi;
    check("ack",       32'(bus.hit_ack),   32'(e_ack));
    check("score",     32'(bus.score_bcd), 32'(int2bcd(m_score)));
    check("hi",        32'(bus.hi_bcd),    32'(int2bcd(m_hi)));
    check("saturated", 32'(bus.saturated), 32'(m_sat));
    check("busy",      32'(bus.busy),      32'(m_eng != 0 || m_hs || m_q.size() != 0));
    check("fifo_full", 32'(bus.fifo_full), 32'(m_q.size() == DEPTH));
    last_ack = bus.hit_ack;
    if (bus.fifo_full) saw_full = 1'b1;
    if (bus.hit_ack != '0) any_ack = 1'b1;

    if (clr) begin
      m_score = 0; m_sat = 1'b0; m_eng = 0; m_hs = 1'b0; m_hidone = 1'b0;
      m_q.delete();
    end else begin
      if (m_hs) begin
        if (m_score > m_hi) m_hi = m_score;
        m_hidone = 1'b1;
        m_hs     = 1'b0;
      end else if (m_eng > 0) begin
        m_eng--;
        if (m_eng == 0) begin
          m_score += m_cur;
          if (m_score > 999) begin
            m_score = 999;
            m_sat   = 1'b1;
          end
          if (go && m_q.size() == 0) m_hs = 1'b1;
        end
      end else if (m_q.size() > 0) begin
        m_cur = m_q.pop_front();
        m_eng = DIG + 1;
      end else if (go && !m_hidone) begin
        m_hs = 1'b1;
      end
      if (gi >= 0) begin
        m_q.push_back(clamp_pts(8'(pts >> (8 * gi))));
        m_rr = (gi + 1) % NSRC;
      end
      if (!go) m_hidone = 1'b0;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [7:0] v);
    logic [8*NSRC-1:0] m;
    m   = (8 * NSRC)'(8'hFF) << (8 * s);
    pts = (pts & ~m) | ((8 * NSRC)'(v) << (8 * s));
    req = req | (NSRC'(1) << s);
  endtask

  task automatic award(input int s, input logic [7:0] v);
    int n;
    n = 0;
    set_src(s, v);
    do begin
      step();
      n++;
    end while (!got_ack(s) && n < 100);
    checks++;
    if (!got_ack(s)) begin
      errors++;
      $display("FAIL ack_timeout src%0d: no ack in 100 cycles, expected one", s);
    end
    req = req & ~(NSRC'(1) << s);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((bus.busy || req != '0) && n < 500) begin
      step();
      req = req & ~last_ack;
      n++;
    end
    checks++;
    if (bus.busy || req != '0) begin
      errors++;
      $display("FAIL drain_timeout: busy=%0b req=%0h after 500 cycles, expected idle", bus.busy,
               req);
    end
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pend[NSRC];
    logic [7:0] r8;

    vecs[0] = '{1'b1, 8'h10, 12'h010, 1'b0};
    vecs[1] = '{1'b1, 8'h95, 12'h095, 1'b0};
    vecs[2] = '{1'b0, 8'h07, 12'h102, 1'b0};
    vecs[3] = '{1'b0, 8'h1F, 12'h121, 1'b0};
    vecs[4] = '{1'b0, 8'hA3, 12'h214, 1'b0};
    vecs[5] = '{1'b1, 8'hFF, 12'h099, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 12'h099, 1'b0};
    last_ack = '0;
    saw_full = 1'b0;
    any_ack  = 1'b0;
    m_reset();

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    check("rst_score", 32'(bus.score_bcd), 32'h0);
    check("rst_hi",    32'(bus.hi_bcd),    32'h0);
    check("rst_busy",  32'(bus.busy),      32'h0);
    check("rst_full",  32'(bus.fifo_full), 32'h0);
    check("rst_sat",   32'(bus.saturated), 32'h0);
    check("rst_ack",   32'(bus.hit_ack),   32'h0);
    reset_n = 1'b1;

    // Single award latency: ack at cycle 0, score visible at cycle 6
    set_src(0, 8'h10);
    step();
    check("t1_ack0", 32'(last_ack), 32'h1);
    req = '0;
    repeat (4) step();
    check("t1_score_c5", 32'(bus.score_bcd), 32'h000);
    step();
    check("t1_score_c6", 32'(bus.score_bcd), 32'h010);
    check("t1_busy_c6",  32'(bus.busy),      32'h0);

    // Vector table: carries, clamping of invalid digits
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].clr_first) pulse_clear();
      award(i % NSRC, vecs[i].pts);
      drain();
      check($sformatf("vec%0d_score", i), 32'(bus.score_bcd), 32'(vecs[i].exp_score));
      check($sformatf("vec%0d_sat", i),   32'(bus.saturated), 32'(vecs[i].exp_sat));
    end

    // Saturation and clear
    pulse_clear();
    for (int i = 0; i < 10; i++) begin
      award(1, 8'h99);
      drain();
    end
    check("t3_990", 32'(bus.score_bcd), 32'h990);
    award(2, 8'h25);
    drain();
    check("t3_sat_score", 32'(bus.score_bcd), 32'h999);
    check("t3_sat_flag",  32'(bus.saturated), 32'h1);
    award(0, 8'h01);
    drain();
    check("t3_sat_hold", 32'(bus.score_bcd), 32'h999);
    pulse_clear();
    check("t3_clr_score", 32'(bus.score_bcd), 32'h000);
    check("t3_clr_sat",   32'(bus.saturated), 32'h0);

    // Round-robin after a grant to src3
    award(3, 8'h00);
    drain();
    set_src(0, 8'h12);
    set_src(2, 8'h34);
    step();
    check("t4_first", 32'(last_ack), 32'h1);
    req = req & ~last_ack;
    step();
    check("t4_second", 32'(last_ack), 32'h4);
    req = req & ~last_ack;
    drain();
    check("t4_sum", 32'(bus.score_bcd), 32'h046);

    // Burst while busy fills the FIFO; held requests eventually acked
    pulse_clear();
    saw_full = 1'b0;
    award(0, 8'h01);
    for (int i = 0; i < NSRC; i++) begin
      pend[i] = 2;
      set_src(i, 8'(8'h11 * (i + 1)));
    end
    for (int n = 0; n < 400 && req != '0; n++) begin
      step();
      for (int i = 0; i < NSRC; i++) begin
        if (got_ack(i)) begin
          pend[i]--;
          if (pend[i] > 0) set_src(i, 8'(5 + i));
          else req = req & ~(NSRC'(1) << i);
        end
      end
    end
    drain();
    check("t5_saw_full", 32'(saw_full), 32'h1);
    check("t5_sum",      32'(bus.score_bcd), 32'h137);

    // Game over: high score latch, intake frozen, drain before HISCORE
    pulse_clear();
    award(0, 8'h99);
    award(1, 8'h01);
    drain();
    go = 1'b1;
    repeat (5) step();
    check("t6_hi100", 32'(bus.hi_bcd), 32'h100);
    go = 1'b0;
    step();
    pulse_clear();
    award(0, 8'h99);
    award(1, 8'h24);
    go = 1'b1;
    set_src(2, 8'h50);
    any_ack = 1'b0;
    repeat (30) step();
    check("t6_hi123",   32'(bus.hi_bcd),    32'h123);
    check("t6_score",   32'(bus.score_bcd), 32'h123);
    check("t6_no_ack",  32'(any_ack),       32'h0);
    go = 1'b0;
    drain();
    check("t6_after_go", 32'(bus.score_bcd), 32'h173);
    pulse_clear();
    award(0, 8'h50);
    drain();
    go = 1'b1;
    repeat (5) step();
    check("t6_hi_kept", 32'(bus.hi_bcd), 32'h123);
    go = 1'b0;
    step();

    // Reset asserted mid-add
    award(0, 8'h55);
    step();
    step();
    reset_n = 1'b0;
    #1;
    check("t7_score", 32'(bus.score_bcd), 32'h0);
    check("t7_hi",    32'(bus.hi_bcd),    32'h0);
    check("t7_busy",  32'(bus.busy),      32'h0);
    check("t7_sat",   32'(bus.saturated), 32'h0);
    check("t7_full",  32'(bus.fifo_full), 32'h0);
    repeat (2) @(posedge Clk);
    #1;
    reset_n = 1'b1;
    m_reset();
    repeat (3) step();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NSRC; i++) begin
        if (!req[i] && $urandom_range(3) == 0) begin
          r8 = 8'($urandom);
          set_src(i, r8);
        end
      end
      clr = ($urandom_range(49) == 0);
      if ($urandom_range(79) == 0) go = ~go;
      step();
      req = req & ~last_ack;
    end
    clr = 1'b0;
    go  = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
